// File: rtl/gb_pkg.sv
// gb_pkg
// Shared definitions for the GameBoy interrupt controller slice:
//   - int_src_e   : interrupt source index, lowest index has highest priority
//   - ADDR_IF/IE  : memory-mapped addresses of the flag and enable registers
//   - int_state_e : dispatch sequencer states
package gb_pkg;

    typedef enum logic [2:0] {
        INT_VBLANK = 3'd0,
        INT_STAT   = 3'd1,
        INT_TIMER  = 3'd2,
        INT_SERIAL = 3'd3,
        INT_JOYPAD = 3'd4
    } int_src_e;

    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_DISPATCH = 1'b1
    } int_state_e;

endpackage

// File: rtl/gb_interrupt_ctrl_if.sv
// gb_interrupt_ctrl_if
// CPU register bus as seen by the interrupt controller.
//   data_i : CPU write data
//   addr   : CPU address
//   wren   : write strobe for addr
//   data_o : read data for addr
// master = CPU side, slave = interrupt controller side.
interface gb_interrupt_ctrl_if;
    logic [7:0]  data_i;
    logic [15:0] addr;
    logic        wren;
    logic [7:0]  data_o;

    modport master (output data_i, output addr, output wren, input data_o);
    modport slave  (input data_i, input addr, input wren, output data_o);
endinterface

// File: rtl/gb_int_priority_enc.sv
// gb_int_priority_enc
// Combinational fixed-priority encoder over the five interrupt sources.
//   req   : pending request vector, bit 0 = VBlank
//   index : lowest set bit index (0 when nothing is set)
//   any   : at least one bit of req is set
module gb_int_priority_enc
    import gb_pkg::*;
(
    input  logic [4:0] req,
    output logic [2:0] index,
    output logic       any
);

    // Lowest index wins, so VBlank always beats the other sources.
    always_comb begin
        any   = |req;
        index = INT_VBLANK;
        casez (req)
            5'b????1: index = INT_VBLANK;
            5'b???10: index = INT_STAT;
            5'b??100: index = INT_TIMER;
            5'b?1000: index = INT_SERIAL;
            5'b10000: index = INT_JOYPAD;
            default:  index = INT_VBLANK;
        endcase
    end

endmodule

// File: rtl/gb_interrupt_ctrl.sv
// gb_interrupt_ctrl
// Central interrupt controller and arbiter: latches request pulses into IF,
// masks with IE and IME, arbitrates VBlank-first and sequences the CPU
// dispatch handshake that produces the vector and clears the serviced flag.
//   clk            : machine clock
//   reset          : asynchronous active-high reset
//   bus            : CPU register bus (IF at FF0F, IE at FFFF)
//   irq_i          : one-cycle request pulses [0]VBlank..[4]Joypad
//   ei_i/di_i      : EI / DI executing
//   reti_i         : RETI executing
//   instr_done_i   : instruction boundary pulse
//   int_start_i    : CPU begins dispatch
//   int_ack_i      : CPU samples the vector
//   int_req_o      : dispatch wanted at next boundary
//   wake_o         : leave HALT
//   int_vector_o   : low byte of jump target
//   vector_valid_o : one-cycle pulse, int_vector_o valid
module gb_interrupt_ctrl
    import gb_pkg::*;
#(
    parameter logic [7:0] VECTOR_BASE   = 8'h40,
    parameter logic [7:0] VECTOR_STRIDE = 8'h08
)(
    input  logic                 clk,
    input  logic                 reset,
    gb_interrupt_ctrl_if.slave   bus,
    input  logic [4:0]           irq_i,
    input  logic                 ei_i,
    input  logic                 di_i,
    input  logic                 reti_i,
    input  logic                 instr_done_i,
    input  logic                 int_start_i,
    input  logic                 int_ack_i,
    output logic                 int_req_o,
    output logic                 wake_o,
    output logic [7:0]           int_vector_o,
    output logic                 vector_valid_o
);

    logic [4:0] if_reg;
    logic [7:0] ie_reg;
    logic       ime;
    logic       ei_delay;
    int_state_e state;
    int_state_e state_next;

    logic [4:0] pending;
    logic [2:0] win_index;
    logic       win_any;
    logic       ack_fire;
    logic [4:0] clear_mask;
    logic [4:0] if_next;
    logic       wr_if;
    logic       wr_ie;

    assign pending  = if_reg & ie_reg[4:0];
    assign ack_fire = (state == ST_DISPATCH) && int_ack_i;
    assign wr_if    = bus.wren && (bus.addr == ADDR_IF);
    assign wr_ie    = bus.wren && (bus.addr == ADDR_IE);

    gb_int_priority_enc u_enc (
        .req   (pending),
        .index (win_index),
        .any   (win_any)
    );

    // Flag update, lowest priority applied first so later terms override:
    // CPU write, then dispatch clear, then a fresh request pulse. A request
    // landing on a clear or write cycle therefore is never lost.
    always_comb begin
        clear_mask = 5'b00000;
        if (ack_fire && win_any) begin
            clear_mask = 5'b00001 << win_index;
        end
        if_next = wr_if ? bus.data_i[4:0] : if_reg;
        if_next = (if_next & ~clear_mask) | irq_i;
    end

    // Register file, including the vector latch that captures the winner
    // at the ack cycle (or 00 when the dispatch was cancelled meanwhile).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_reg         <= 5'h00;
            ie_reg         <= 8'h00;
            int_vector_o   <= 8'h00;
            vector_valid_o <= 1'b0;
        end else begin
            if_reg         <= if_next;
            vector_valid_o <= ack_fire;
            if (wr_ie) begin
                ie_reg <= bus.data_i;
            end
            if (ack_fire) begin
                int_vector_o <= win_any ? (VECTOR_BASE + 8'(win_index) * VECTOR_STRIDE) : 8'h00;
            end
        end
    end

    // Master enable. DI dominates everything; dispatch entry also disables.
    // EI only arms ei_delay so IME turns on after the following instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ime      <= 1'b0;
            ei_delay <= 1'b0;
        end else if (di_i || int_start_i) begin
            ime      <= 1'b0;
            ei_delay <= 1'b0;
        end else begin
            if (reti_i) begin
                ime <= 1'b1;
            end
            if (ei_i) begin
                ei_delay <= 1'b1;
            end else if (instr_done_i && ei_delay) begin
                ime      <= 1'b1;
                ei_delay <= 1'b0;
            end
        end
    end

    // Dispatch sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: leave IDLE on start, return on the ack edge, which is
    // also the edge that raises vector_valid_o.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (int_start_i) state_next = ST_DISPATCH;
            ST_DISPATCH: if (int_ack_i)   state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    assign wake_o    = |pending;
    assign int_req_o = ime && (|pending) && (state == ST_IDLE);

    // Unused IF bits read back as ones; unmapped addresses float high.
    always_comb begin
        bus.data_o = 8'hFF;
        if (bus.addr == ADDR_IF) begin
            bus.data_o = {3'b111, if_reg};
        end else if (bus.addr == ADDR_IE) begin
            bus.data_o = ie_reg;
        end
    end

endmodule

// File: tb/tb_gb_interrupt_ctrl.sv
// tb_gb_interrupt_ctrl
// Self-checking bench for gb_interrupt_ctrl: directed scenarios with literal
// expectations followed by randomized traffic, all outputs compared every
// cycle against a behavioural model of the controller.
module tb_gb_interrupt_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] irq_i;
    logic       ei_i, di_i, reti_i, instr_done_i, int_start_i, int_ack_i;
    logic       int_req_o, wake_o, vector_valid_o;
    logic [7:0] int_vector_o;

    gb_interrupt_ctrl_if bus ();

    gb_interrupt_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus.slave),
        .irq_i          (irq_i),
        .ei_i           (ei_i),
        .di_i           (di_i),
        .reti_i         (reti_i),
        .instr_done_i   (instr_done_i),
        .int_start_i    (int_start_i),
        .int_ack_i      (int_ack_i),
        .int_req_o      (int_req_o),
        .wake_o         (wake_o),
        .int_vector_o   (int_vector_o),
        .vector_valid_o (vector_valid_o)
    );

    int vectors = 0;
    int miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    bit [4:0] m_if;
    bit [7:0] m_ie;
    bit       m_ime, m_eid, m_disp, m_vv;
    bit [7:0] m_vec;
    bit [4:0] m_pend, m_new_if;
    int       m_win;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: applies the register, IME and dispatch rules at each edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_if = 0; m_ie = 0; m_ime = 0; m_eid = 0; m_disp = 0; m_vv = 0; m_vec = 0;
        end else begin
            m_pend = m_if & m_ie[4:0];
            m_win = -1;
            for (int i = 4; i >= 0; i--) if (m_pend[i]) m_win = i;
            m_new_if = m_if;
            if (bus.wren && bus.addr == 16'hFF0F) m_new_if = bus.data_i[4:0];
            m_vv = 0;
            if (m_disp && int_ack_i) begin
                m_vv = 1;
                if (m_win >= 0) begin
                    m_new_if[m_win] = 1'b0;
                    m_vec = 8'(64 + 8 * m_win);
                end else begin
                    m_vec = 8'h00;
                end
            end
            m_new_if = m_new_if | irq_i;
            if (bus.wren && bus.addr == 16'hFFFF) m_ie = bus.data_i;
            if (di_i || int_start_i) begin
                m_ime = 0; m_eid = 0;
            end else begin
                if (reti_i) m_ime = 1;
                if (ei_i) m_eid = 1;
                else if (instr_done_i && m_eid) begin m_ime = 1; m_eid = 0; end
            end
            if (!m_disp) m_disp = int_start_i;
            else if (int_ack_i) m_disp = 0;
            m_if = m_new_if;
        end
    end

    // Compare process: every mid-cycle, all outputs against the model.
    always @(negedge clk) begin
        logic [4:0] p;
        logic [7:0] rd;
        p  = m_if & m_ie[4:0];
        rd = (bus.addr == 16'hFF0F) ? {3'b111, m_if} :
             (bus.addr == 16'hFFFF) ? m_ie : 8'hFF;
        check_output("int_req", {7'd0, int_req_o}, {7'd0, m_ime && (|p) && !m_disp});
        check_output("wake", {7'd0, wake_o}, {7'd0, |p});
        check_output("vector_valid", {7'd0, vector_valid_o}, {7'd0, m_vv});
        check_output("int_vector", int_vector_o, m_vec);
        check_output("data_o", bus.data_o, rd);
    end

    task automatic clear_inputs();
        irq_i = 0; ei_i = 0; di_i = 0; reti_i = 0; instr_done_i = 0;
        int_start_i = 0; int_ack_i = 0;
        bus.wren = 0; bus.data_i = 0; bus.addr = 16'h0000;
    endtask

    // Holds the currently driven inputs across exactly one rising edge.
    task automatic apply_stimulus();
        @(posedge clk);
        #2;
        clear_inputs();
    endtask

    task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
        bus.wren = 1; bus.addr = a; bus.data_i = d;
        apply_stimulus();
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic [7:0] exp);
        bus.addr = a;
        #1;
        check_output(name, bus.data_o, exp);
    endtask

    task automatic pulse_ctrl(input int which);
        case (which)
            0: ei_i = 1;
            1: di_i = 1;
            2: reti_i = 1;
            3: instr_done_i = 1;
            4: int_start_i = 1;
            5: int_ack_i = 1;
            default: ;
        endcase
        apply_stimulus();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_output("reset_int_vector", int_vector_o, 8'h00);
        check_output("reset_valid", {7'd0, vector_valid_o}, 8'h00);
        read_check("reset_if_read", 16'hFF0F, 8'hE0);
        read_check("reset_ie_read", 16'hFFFF, 8'h00);
        read_check("other_read", 16'hC000, 8'hFF);
        reset = 1'b0;
        apply_stimulus();

        // Priority: VBlank beats Timer, then Timer on the second round.
        write_reg(16'hFFFF, 8'h1F);
        pulse_ctrl(2);
        irq_i = 5'b00101; apply_stimulus();
        check_output("prio_req", {7'd0, int_req_o}, 8'h01);
        pulse_ctrl(4);
        pulse_ctrl(5);
        check_output("prio_valid", {7'd0, vector_valid_o}, 8'h01);
        check_output("prio_vec", int_vector_o, 8'h40);
        read_check("prio_if", 16'hFF0F, 8'hE4);
        pulse_ctrl(2);
        pulse_ctrl(4);
        pulse_ctrl(5);
        check_output("prio_vec2", int_vector_o, 8'h50);
        read_check("prio_if2", 16'hFF0F, 8'hE0);

        // EI delay, then DI between the two boundaries.
        write_reg(16'hFFFF, 8'h04);
        irq_i = 5'b00100; apply_stimulus();
        ei_i = 1; instr_done_i = 1; apply_stimulus();
        check_output("ei_req_early", {7'd0, int_req_o}, 8'h00);
        pulse_ctrl(3);
        check_output("ei_req_late", {7'd0, int_req_o}, 8'h01);
        pulse_ctrl(4);
        pulse_ctrl(5);
        check_output("ei_vec", int_vector_o, 8'h50);
        irq_i = 5'b00100; apply_stimulus();
        ei_i = 1; instr_done_i = 1; apply_stimulus();
        pulse_ctrl(1);
        pulse_ctrl(3);
        check_output("di_req", {7'd0, int_req_o}, 8'h00);

        // Cancelled dispatch: IE cleared while the push is in flight.
        pulse_ctrl(2);
        pulse_ctrl(4);
        write_reg(16'hFFFF, 8'h00);
        pulse_ctrl(5);
        check_output("cancel_valid", {7'd0, vector_valid_o}, 8'h01);
        check_output("cancel_vec", int_vector_o, 8'h00);
        read_check("cancel_if", 16'hFF0F, 8'hE4);
        write_reg(16'hFFFF, 8'h04);
        check_output("cancel_ime_off", {7'd0, int_req_o}, 8'h00);
        check_output("cancel_wake", {7'd0, wake_o}, 8'h01);

        // Collisions: request beats CPU write and dispatch clear.
        irq_i = 5'b00100; bus.wren = 1; bus.addr = 16'hFF0F; bus.data_i = 8'h00;
        apply_stimulus();
        read_check("coll_write", 16'hFF0F, 8'hE4);
        write_reg(16'hFFFF, 8'h01);
        write_reg(16'hFF0F, 8'h01);
        pulse_ctrl(2);
        pulse_ctrl(4);
        irq_i = 5'b00001; int_ack_i = 1; apply_stimulus();
        check_output("coll_vec", int_vector_o, 8'h40);
        read_check("coll_clear", 16'hFF0F, 8'hE1);

        // HALT wake without IME, then reset in the middle of a dispatch.
        write_reg(16'hFF0F, 8'h00);
        write_reg(16'hFFFF, 8'h10);
        pulse_ctrl(1);
        irq_i = 5'b10000; apply_stimulus();
        check_output("halt_wake", {7'd0, wake_o}, 8'h01);
        check_output("halt_req", {7'd0, int_req_o}, 8'h00);
        pulse_ctrl(4);
        reset = 1'b1;
        #1;
        check_output("rst_req", {7'd0, int_req_o}, 8'h00);
        check_output("rst_wake", {7'd0, wake_o}, 8'h00);
        check_output("rst_valid", {7'd0, vector_valid_o}, 8'h00);
        check_output("rst_vec", int_vector_o, 8'h00);
        read_check("rst_if", 16'hFF0F, 8'hE0);
        apply_stimulus();
        reset = 1'b0;
        apply_stimulus();

        // Randomized traffic checked by the compare process.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 3) == 0) irq_i = 5'(1 << $urandom_range(0, 4));
            if ($urandom_range(0, 15) == 0) irq_i = 5'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                bus.wren = 1;
                case ($urandom_range(0, 2))
                    0: bus.addr = 16'hFF0F;
                    1: bus.addr = 16'hFFFF;
                    default: bus.addr = 16'($urandom);
                endcase
                bus.data_i = 8'($urandom);
            end else begin
                bus.addr = ($urandom_range(0, 1) == 0) ? 16'hFF0F : 16'hFFFF;
            end
            case ($urandom_range(0, 9))
                0: ei_i = 1;
                1: di_i = 1;
                2: reti_i = 1;
                3: instr_done_i = 1;
                4: begin ei_i = 1; instr_done_i = 1; end
                5: if (!m_disp) int_start_i = 1;
                6, 7: int_ack_i = 1;
                8: begin di_i = 1; ei_i = 1; end
                default: ;
            endcase
            if ($urandom_range(0, 599) == 0) reset = 1'b1;
            apply_stimulus();
            reset = 1'b0;
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
